// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   IF/ID pipeline register and instruction field splitter for the 5-stage
//   LEGv8 core. Captures the fetched instruction and its PC, classifies the
//   instruction format and presents the raw (not sign-extended) immediate
//   and register fields, all registered with 1-cycle latency.
//
//   Priority at every rising edge: reset > flush > stall > capture.
//
// Parameters
//   PC_WIDTH   width of the captured program counter
//   NOP_INSTR  instruction word shown on reset, flush or bubble
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold every output register
//   flush               load a bubble, PC held
//   in_valid/in_instr/in_pc   fetch-side instruction, PC and validity
//   out_valid/out_instr/out_pc registered instruction, PC and validity
//   out_fmt             0 NONE, 1 R, 2 I, 3 D, 4 B, 5 CB
//   out_illegal         valid instruction with an unrecognised opcode
//   imm9/imm12/imm19/imm26   raw offset / immediate slices
//   rd_rt, rn, rm       raw register specifier slices
//
// Optional feature (macro IF_ID_PERF_CNT_EN)
//   Adds 32-bit wrapping counters stall_cnt, flush_cnt, bubble_cnt that count
//   the edges where stall, flush or an invalid-fetch capture is the winning
//   action. Reset clears them.
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int unsigned PC_WIDTH  = 64,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [2:0]          out_fmt,
  output logic                out_illegal,
  output logic [8:0]          imm9,
  output logic [11:0]         imm12,
  output logic [18:0]         imm19,
  output logic [25:0]         imm26,
  output logic [4:0]          rd_rt,
  output logic [4:0]          rn,
  output logic [4:0]          rm
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_D    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_CB   = 3'd5;

  // Format classification; checked B, CB, D, I, R so the first match wins.
  function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
    logic [2:0] fmt;
    fmt = FMT_NONE;
    if ((instr[31:26] == 6'b000101) || (instr[31:26] == 6'b100101)) begin
      fmt = FMT_B;
    end else if ((instr[31:24] == 8'b10110100) || (instr[31:24] == 8'b10110101) ||
                 (instr[31:24] == 8'b01010100)) begin
      fmt = FMT_CB;
    end else if ((instr[31:21] == 11'b11111000010) || (instr[31:21] == 11'b11111000000)) begin
      fmt = FMT_D;
    end else if ((instr[31:22] == 10'b1001000100) || (instr[31:22] == 10'b1101000100)) begin
      fmt = FMT_I;
    end else begin
      case (instr[31:21])
        11'b10001011000, 11'b11001011000, 11'b10101011000, 11'b11101011000,
        11'b10001010000, 11'b10101010000, 11'b11001010000, 11'b11010011011,
        11'b11010011010: fmt = FMT_R;
        default:         fmt = FMT_NONE;
      endcase
    end
    return fmt;
  endfunction

  logic                valid_q,   valid_d;
  logic [31:0]         instr_q,   instr_d;
  logic [PC_WIDTH-1:0] pc_q,      pc_d;
  logic [2:0]          fmt_q,     fmt_d;
  logic                illegal_q, illegal_d;
  // Copy of the captured word that is forced to zero in a bubble, so the
  // field slices read zero even when NOP_INSTR is non-zero.
  logic [31:0]         field_q,   field_d;
  logic [2:0]          cap_fmt_s;

  assign cap_fmt_s = decode_fmt(in_instr);

  // Next-state selection: flush > stall > capture (reset handled in the flop).
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    fmt_d     = fmt_q;
    illegal_d = illegal_q;
    field_d   = field_q;
    if (flush) begin
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      fmt_d     = FMT_NONE;
      illegal_d = 1'b0;
      field_d   = 32'h0000_0000;
    end else if (stall) begin
      valid_d   = valid_q;
    end else if (in_valid) begin
      valid_d   = 1'b1;
      instr_d   = in_instr;
      pc_d      = in_pc;
      fmt_d     = cap_fmt_s;
      illegal_d = (cap_fmt_s == FMT_NONE);
      field_d   = in_instr;
    end else begin
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      pc_d      = in_pc;
      fmt_d     = FMT_NONE;
      illegal_d = 1'b0;
      field_d   = 32'h0000_0000;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      fmt_q     <= FMT_NONE;
      illegal_q <= 1'b0;
      field_q   <= 32'h0000_0000;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      fmt_q     <= fmt_d;
      illegal_q <= illegal_d;
      field_q   <= field_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = pc_q;
  assign out_fmt     = fmt_q;
  assign out_illegal = illegal_q;
  assign imm9        = field_q[20:12];
  assign imm12       = field_q[21:10];
  assign imm19       = field_q[23:5];
  assign imm26       = field_q[25:0];
  assign rd_rt       = field_q[4:0];
  assign rn          = field_q[9:5];
  assign rm          = field_q[20:16];

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counter increments follow the same priority as the stage registers.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      flush_cnt_d  = flush_cnt_q + 32'd1;
    end else if (stall) begin
      stall_cnt_d  = stall_cnt_q + 32'd1;
    end else if (!in_valid) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Performance counter registers, cleared by reset, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//   Scoreboard bench for if_id_stage. A driver applies directed vectors on
//   the falling edge and pushes the hand-computed expected stage contents;
//   a monitor pops one entry after every rising edge and compares.
//   Field expectations are slices of the expected field word (zero in a
//   bubble). Counter expectations are kept only when IF_ID_PERF_CNT_EN is set.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clk;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid, out_illegal;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  out_fmt;
  logic [8:0]  imm9;
  logic [11:0] imm12;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic [4:0]  rd_rt, rn, rm;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, bubble_cnt;
`endif

  if_id_stage #(.PC_WIDTH(64), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_fmt(out_fmt), .out_illegal(out_illegal),
    .imm9(imm9), .imm12(imm12), .imm19(imm19), .imm26(imm26),
    .rd_rt(rd_rt), .rn(rn), .rm(rm)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        illegal;
    logic [31:0] field;
    logic [31:0] scnt, fcnt, bcnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;
  logic [31:0] m_scnt = 32'd0, m_fcnt = 32'd0, m_bcnt = 32'd0;
  bit   done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Apply one vector on the falling edge and queue the contents expected after the next rising edge.
  task automatic step(input logic rst, input logic stl, input logic fl, input logic vld,
                      input logic [31:0] instr, input logic [63:0] pc,
                      input logic e_valid, input logic [31:0] e_instr, input logic [63:0] e_pc,
                      input logic [2:0] e_fmt, input logic e_ill);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; flush = fl; in_valid = vld; in_instr = instr; in_pc = pc;
    if (rst) begin
      m_scnt = 32'd0; m_fcnt = 32'd0; m_bcnt = 32'd0;
    end else if (fl) begin
      m_fcnt = m_fcnt + 32'd1;
    end else if (stl) begin
      m_scnt = m_scnt + 32'd1;
    end else if (!vld) begin
      m_bcnt = m_bcnt + 32'd1;
    end
    e.valid = e_valid; e.instr = e_instr; e.pc = e_pc; e.fmt = e_fmt; e.illegal = e_ill;
    e.field = e_valid ? e_instr : 32'h0000_0000;
    e.scnt = m_scnt; e.fcnt = m_fcnt; e.bcnt = m_bcnt;
    q.push_back(e);
  endtask

  // Monitor: one pop and full comparison shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vec_no++;
        chk("out_valid",   vec_no, {63'd0, out_valid},   {63'd0, e.valid});
        chk("out_instr",   vec_no, {32'd0, out_instr},   {32'd0, e.instr});
        chk("out_pc",      vec_no, out_pc,               e.pc);
        chk("out_fmt",     vec_no, {61'd0, out_fmt},     {61'd0, e.fmt});
        chk("out_illegal", vec_no, {63'd0, out_illegal}, {63'd0, e.illegal});
        chk("imm9",        vec_no, {55'd0, imm9},        {55'd0, e.field[20:12]});
        chk("imm12",       vec_no, {52'd0, imm12},       {52'd0, e.field[21:10]});
        chk("imm19",       vec_no, {45'd0, imm19},       {45'd0, e.field[23:5]});
        chk("imm26",       vec_no, {38'd0, imm26},       {38'd0, e.field[25:0]});
        chk("rd_rt",       vec_no, {59'd0, rd_rt},       {59'd0, e.field[4:0]});
        chk("rn",          vec_no, {59'd0, rn},          {59'd0, e.field[9:5]});
        chk("rm",          vec_no, {59'd0, rm},          {59'd0, e.field[20:16]});
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cnt",   vec_no, {32'd0, stall_cnt},   {32'd0, e.scnt});
        chk("flush_cnt",   vec_no, {32'd0, flush_cnt},   {32'd0, e.fcnt});
        chk("bubble_cnt",  vec_no, {32'd0, bubble_cnt},  {32'd0, e.bcnt});
`endif
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int budget;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = 32'h0000_0000; in_pc = 64'h0;
    //    rst  stl  fl   vld  in_instr       in_pc    e_vld e_instr        e_pc     fmt   ill
    step(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,64'h00,  1'b0,32'h0000_0000,64'h00,  3'd0,1'b0);
    step(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,64'h00,  1'b0,32'h0000_0000,64'h00,  3'd0,1'b0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0000_0000,64'h3C,  1'b0,32'h0000_0000,64'h3C,  3'd0,1'b0);
    // LDUR X1,[X2,#-8]: D, imm9=1F8, rn=2, rd_rt=1
    step(1'b0,1'b0,1'b0,1'b1,32'hF85F_8041,64'h40,  1'b1,32'hF85F_8041,64'h40,  3'd3,1'b0);
    // ADDI X3,X4,#5: I, imm12=5, rn=4, rd_rt=3; then hold through 3 stalls
    step(1'b0,1'b0,1'b0,1'b1,32'h9100_1483,64'h44,  1'b1,32'h9100_1483,64'h44,  3'd2,1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0,1'b1,1'b0,1'b1,32'h17FF_FFFF,64'h48,1'b1,32'h9100_1483,64'h44,  3'd2,1'b0);
    // stall released: B, imm26=3FFFFFF
    step(1'b0,1'b0,1'b0,1'b1,32'h17FF_FFFF,64'h48,  1'b1,32'h17FF_FFFF,64'h48,  3'd4,1'b0);
    // CBZ X0,+2: CB, imm19=2; then flush with stall -> bubble, pc held
    step(1'b0,1'b0,1'b0,1'b1,32'hB400_0040,64'h4C,  1'b1,32'hB400_0040,64'h4C,  3'd5,1'b0);
    step(1'b0,1'b1,1'b1,1'b1,32'h9100_1483,64'h50,  1'b0,32'h0000_0000,64'h4C,  3'd0,1'b0);
    step(1'b0,1'b0,1'b1,1'b1,32'h9100_1483,64'h54,  1'b0,32'h0000_0000,64'h4C,  3'd0,1'b0);
    // ADD X0,X1,X2: R
    step(1'b0,1'b0,1'b0,1'b1,32'h8B02_0020,64'h58,  1'b1,32'h8B02_0020,64'h58,  3'd1,1'b0);
    // invalid fetch: bubble, pc follows in_pc
    step(1'b0,1'b0,1'b0,1'b0,32'h8B02_0020,64'h5C,  1'b0,32'h0000_0000,64'h5C,  3'd0,1'b0);
    // unrecognised opcode, held by stall, then reset during stall
    step(1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFF,64'h60,  1'b1,32'hFFFF_FFFF,64'h60,  3'd0,1'b1);
    step(1'b0,1'b1,1'b0,1'b1,32'h8B02_0020,64'h64,  1'b1,32'hFFFF_FFFF,64'h60,  3'd0,1'b1);
    step(1'b1,1'b1,1'b0,1'b1,32'h8B02_0020,64'h64,  1'b0,32'h0000_0000,64'h00,  3'd0,1'b0);
    step(1'b0,1'b1,1'b0,1'b1,32'h8B02_0020,64'h64,  1'b0,32'h0000_0000,64'h00,  3'd0,1'b0);
    // remaining opcode classes and a near-miss R opcode
    step(1'b0,1'b0,1'b0,1'b1,32'hD100_0000,64'h64,  1'b1,32'hD100_0000,64'h64,  3'd2,1'b0);
    step(1'b0,1'b0,1'b0,1'b1,32'h5400_0000,64'h68,  1'b1,32'h5400_0000,64'h68,  3'd5,1'b0);
    step(1'b0,1'b0,1'b0,1'b1,32'hF800_0000,64'h6C,  1'b1,32'hF800_0000,64'h6C,  3'd3,1'b0);
    step(1'b0,1'b0,1'b0,1'b1,32'h9400_0000,64'h70,  1'b1,32'h9400_0000,64'h70,  3'd4,1'b0);
    step(1'b0,1'b0,1'b0,1'b1,32'h8B20_0000,64'h74,  1'b1,32'h8B20_0000,64'h74,  3'd0,1'b1);
    step(1'b0,1'b0,1'b0,1'b1,32'hAB1F_03E0,64'h78,  1'b1,32'hAB1F_03E0,64'h78,  3'd1,1'b0);
    // drain with a bounded wait on the scoreboard
    @(negedge clk);
    in_valid = 1'b0; stall = 1'b1;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
    end
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register and instruction field splitter for the 5-stage LEGv8 core.
- Captures each fetched 32-bit instruction and its PC, classifies the instruction format, and presents the raw immediate fields registered.
- The raw fields feed the per-width sign extenders (9, 12, 19, 26 bit) and the register file in the decode stage.
- Supports stall (hold), flush (bubble) and fetch-side invalid (bubble).

Parameters:
- PC_WIDTH, 64, width of the captured program counter.
- NOP_INSTR, 32'h0000_0000, instruction word loaded on reset, flush or bubble.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all registered outputs this cycle
- flush  input  1  replace stage contents with a bubble (branch taken)
- in_valid  input  1  fetch presents a real instruction
- in_instr  input  32  fetched instruction
- in_pc  input  PC_WIDTH  PC of in_instr
- out_valid  output  1  registered instruction is real
- out_instr  output  32  registered instruction
- out_pc  output  PC_WIDTH  registered PC
- out_fmt  output  3  0 NONE, 1 R, 2 I, 3 D, 4 B, 5 CB
- out_illegal  output  1  out_valid=1 but opcode unrecognised
- imm9  output  9  instr[20:12] (D-type offset)
- imm12  output  12  instr[21:10] (I-type immediate)
- imm19  output  19  instr[23:5] (CB-type offset)
- imm26  output  26  instr[25:0] (B-type offset)
- rd_rt  output  5  instr[4:0]
- rn  output  5  instr[9:5]
- rm  output  5  instr[20:16]

Behaviour:
- All outputs are registered. Latency is 1 cycle from in_* to out_*. There is no combinational path from input to output.
- Reset: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_fmt=0, out_illegal=0, all fields=0. Reset overrides flush and stall, and takes effect mid-stall.
- Priority each posedge: reset > flush > stall > capture.
- Flush: load a bubble (same values as reset, except out_pc is held). A flush asserted together with stall still produces a bubble.
- Stall: every output register holds its value. in_* is ignored.
- Capture with in_valid=1: register in_instr and in_pc, set out_valid=1, and decode the format from in_instr:
  - B: [31:26] in {000101, 100101}
  - CB: [31:24] in {10110100, 10110101, 01010100}
  - D: [31:21] in {11111000010, 11111000000}
  - I: [31:22] in {1001000100, 1101000100}
  - R: [31:21] in {10001011000, 11001011000, 10101011000, 11101011000, 10001010000, 10101010000, 11001010000, 11010011011, 11010011010}
  - Decode is checked in that order; the first match wins.
  - No match: out_fmt=0 and out_illegal=1.
- Capture with in_valid=0: load a bubble; out_pc takes in_pc.
- Field outputs are raw bit slices of the captured word and are not sign-extended. They are valid whenever out_valid=1 and are zero in a bubble.
- out_illegal is never 1 while out_valid=0.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cnt, flush_cnt, bubble_cnt, each 32 bits.
  - Each counter increments by 1 on every non-reset posedge where its condition is the winning action. bubble_cnt counts capture with in_valid=0.
  - Counters wrap from 32'hFFFF_FFFF to 0.
  - Reset clears all counters to 0.
- Undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> out_valid=0, out_instr=0, out_fmt=0, all fields 0.
- in_instr=32'hF85F8041 (LDUR X1,[X2,#-8]), in_pc=64'h40, in_valid=1 -> next cycle: out_fmt=3, imm9=9'h1F8, rn=2, rd_rt=1, out_pc=64'h40, out_illegal=0.
- 32'h91001483 (ADDI X3,X4,#5) captured, then stall=1 for 3 cycles while in_instr=32'h17FFFFFF -> outputs hold fmt=2, imm12=5, rn=4, rd_rt=3. Releasing stall captures fmt=4, imm26=26'h3FFFFFF.
- 32'hB4000040 (CBZ X0,+2) captured, then flush=1 and stall=1 together -> out_valid=0, fmt=0, imm19=0. The cycle before the flush shows imm19=2, fmt=5.
- in_instr=32'hFFFFFFFF, in_valid=1 -> out_valid=1, fmt=0, out_illegal=1. Then reset during stall -> all outputs cleared next edge.
- With IF_ID_PERF_CNT_EN: 3 stalls, 2 flushes, 1 invalid cycle -> stall_cnt=3, flush_cnt=2, bubble_cnt=1. Reset -> all counters 0.
